// File: rtl/uart_pixel_loader.sv
// Packet parser between the UART byte receiver and the frame-buffer write port.
// Decodes SYNC/CMD framed packets into set-pointer, run-length fill and raw pixel writes.
module uart_pixel_loader #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        err_clr,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        busy,
    output logic        pkt_done,
    output logic        err_cmd,
    output logic        err_ovr,
    output logic        err_tmo
);

    localparam int unsigned MAX_ADDR = WIDTH * HEIGHT;
    localparam int unsigned TmoW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [18:0] LastAddr = 19'(MAX_ADDR - 1);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StLen, StColor, StFill, StRaw
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             is_fill_q, is_fill_d;
    logic [15:0]      addr_sr_q, addr_sr_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       color_q, color_d;
    logic [18:0]      ptr_q, ptr_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             done_pend_q, done_pend_d;
    logic             wr_en_q, wr_en_d;
    logic [18:0]      wr_addr_q, wr_addr_d;
    logic [2:0]       wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             pkt_done_q, pkt_done_d;
    logic             err_cmd_q, err_cmd_d;
    logic             err_ovr_q, err_ovr_d;
    logic             err_tmo_q, err_tmo_d;

    logic [18:0]      ptr_next;
    logic [23:0]      addr_full;
    logic             addr_ok;
    logic [15:0]      len_full;
    logic             tmo_run;
    logic             tmo_hit;
    logic             set_cmd, set_ovr, set_tmo;

    assign ptr_next  = (ptr_q == LastAddr) ? 19'd0 : ptr_q + 19'd1;
    assign addr_full = {addr_sr_q, rx_data};
    assign addr_ok   = ({13'd0, addr_full[18:0]} < 32'(MAX_ADDR));
    assign len_full  = {len_hi_q, rx_data};
    assign tmo_run   = (state_q == StCmd) || (state_q == StAddr) || (state_q == StLen) ||
                       (state_q == StColor) || (state_q == StRaw);
    assign tmo_hit   = tmo_run && !rx_valid && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_fill_d   = is_fill_q;
        addr_sr_d   = addr_sr_q;
        len_hi_d    = len_hi_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        ptr_d       = ptr_q;
        tmo_d       = (tmo_run && !rx_valid) ? tmo_q + TmoW'(1) : '0;
        done_pend_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pkt_done_d  = done_pend_q;
        set_cmd     = 1'b0;
        set_ovr     = 1'b0;
        set_tmo     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = StCmd;
            end
            StCmd: begin
                if (rx_valid) begin
                    byte_cnt_d = 2'd0;
                    case (rx_data)
                        8'h01:   state_d = StAddr;
                        8'h02: begin
                            is_fill_d = 1'b1;
                            state_d   = StLen;
                        end
                        8'h03: begin
                            is_fill_d = 1'b0;
                            state_d   = StLen;
                        end
                        default: begin
                            set_cmd = 1'b1;
                            state_d = StIdle;
                        end
                    endcase
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    addr_sr_d  = {addr_sr_q[7:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd2) begin
                        state_d = StIdle;
                        if (addr_ok) begin
                            ptr_d      = addr_full[18:0];
                            pkt_done_d = 1'b1;
                        end else begin
                            set_cmd = 1'b1;
                        end
                    end
                end
            end
            StLen: begin
                if (rx_valid) begin
                    len_hi_d   = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        cnt_d = len_full;
                        if (len_full == 16'd0) begin
                            state_d    = StIdle;
                            pkt_done_d = 1'b1;
                        end else begin
                            state_d = is_fill_q ? StColor : StRaw;
                        end
                    end
                end
            end
            StColor: begin
                if (rx_valid) begin
                    color_d   = rx_data[2:0];
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_data[2:0];
                    ptr_d     = ptr_next;
                    cnt_d     = cnt_q - 16'd1;
                    state_d   = StFill;
                end
            end
            StFill: begin
                // Bytes arriving mid-fill are dropped; the fill keeps running.
                if (rx_valid) set_ovr = 1'b1;
                if (cnt_q == 16'd0) begin
                    state_d    = StIdle;
                    pkt_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = color_q;
                    ptr_d     = ptr_next;
                    cnt_d     = cnt_q - 16'd1;
                end
            end
            StRaw: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_data[2:0];
                    ptr_d     = ptr_next;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        // pkt_done follows the cycle of the final write.
                        state_d     = StIdle;
                        done_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            set_tmo = 1'b1;
            state_d = StIdle;
        end

        busy_d    = (state_d == StFill);
        err_cmd_d = (err_cmd_q && !err_clr) || set_cmd;
        err_ovr_d = (err_ovr_q && !err_clr) || set_ovr;
        err_tmo_d = (err_tmo_q && !err_clr) || set_tmo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_cnt_q  <= 2'd0;
            is_fill_q   <= 1'b0;
            addr_sr_q   <= 16'd0;
            len_hi_q    <= 8'd0;
            cnt_q       <= 16'd0;
            color_q     <= 3'd0;
            ptr_q       <= 19'd0;
            tmo_q       <= '0;
            done_pend_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 19'd0;
            wr_data_q   <= 3'd0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_fill_q   <= is_fill_d;
            addr_sr_q   <= addr_sr_d;
            len_hi_q    <= len_hi_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            ptr_q       <= ptr_d;
            tmo_q       <= tmo_d;
            done_pend_q <= done_pend_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            err_cmd_q   <= err_cmd_d;
            err_ovr_q   <= err_ovr_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign pkt_done = pkt_done_q;
    assign err_cmd  = err_cmd_q;
    assign err_ovr  = err_ovr_q;
    assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: packet-level reference model with
// randomized packets, wrap, error, timeout and reset scenarios.
module tb_uart_pixel_loader;

    localparam int unsigned Tmo = 64;
    localparam int MaxA = 640 * 480;

    typedef struct { int addr; int data; int cyc; } obs_t;
    typedef struct { int addr; int data; } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        err_clr;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy, pkt_done, err_cmd, err_ovr, err_tmo;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    obs_t wq[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_cnt = 0;
    int   bad_addr = 0;

    exp_t       ew[$];
    int         rcyc[$];
    logic [7:0] raw_src[$];
    int         m_ptr = 0;
    int         exp_done = 0;
    int         w_base, d_base, b_base, byte_cyc;

    uart_pixel_loader #(.TIMEOUT_CYC(Tmo)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .err_clr  (err_clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .pkt_done (pkt_done),
        .err_cmd  (err_cmd),
        .err_ovr  (err_ovr),
        .err_tmo  (err_tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back('{int'(wr_addr), int'(wr_data), cyc});
            if (int'(wr_addr) >= MaxA) bad_addr++;
        end
        if (pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        byte_cyc = cyc;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic mark();
        w_base = wq.size();
        d_base = done_cnt;
        b_base = busy_cnt;
        ew.delete();
        rcyc.delete();
        exp_done = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (done_cnt - d_base) < exp_done; i++) tick();
        repeat (3) tick();
    endtask

    task automatic pkt_addr(input int a, input int gap);
        logic [23:0] av;
        av = 24'(a);
        send(8'hA5, gap);
        send(8'h01, gap);
        send(av[23:16], gap);
        send(av[15:8], gap);
        send(av[7:0], gap);
        if (a < MaxA) begin
            m_ptr = a;
            exp_done++;
        end
    endtask

    task automatic pkt_fill(input int len, input logic [7:0] col, input int gap);
        logic [15:0] lv;
        lv = 16'(len);
        send(8'hA5, gap);
        send(8'h02, gap);
        send(lv[15:8], gap);
        send(lv[7:0], gap);
        send(col, 0);
        for (int i = 0; i < len; i++) begin
            ew.push_back('{m_ptr, int'(col[2:0])});
            m_ptr = (m_ptr + 1) % MaxA;
        end
        exp_done++;
    endtask

    task automatic pkt_raw(input int len, input int gap);
        logic [15:0] lv;
        logic [7:0]  b;
        lv = 16'(len);
        send(8'hA5, gap);
        send(8'h03, gap);
        send(lv[15:8], gap);
        send(lv[7:0], gap);
        for (int i = 0; i < len; i++) begin
            b = (raw_src.size() > 0) ? raw_src.pop_front() : 8'($urandom);
            send(b, gap);
            rcyc.push_back(byte_cyc);
            ew.push_back('{m_ptr, int'(b[2:0])});
            m_ptr = (m_ptr + 1) % MaxA;
        end
        exp_done++;
    endtask

    function automatic int wr_mismatch();
        int n = wq.size() - w_base;
        int bad = (n > ew.size()) ? n - ew.size() : ew.size() - n;
        for (int i = 0; i < n && i < ew.size(); i++)
            if (wq[w_base + i].addr != ew[i].addr || wq[w_base + i].data != ew[i].data) bad++;
        return bad;
    endfunction

    function automatic int raw_lat_bad();
        int bad = 0;
        for (int i = 0; i < rcyc.size(); i++)
            if (w_base + i >= wq.size() || wq[w_base + i].cyc != rcyc[i] + 1) bad++;
        return bad;
    endfunction

    function automatic int last_wr_cyc();
        return (wq.size() > w_base) ? wq[wq.size() - 1].cyc : -100;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; err_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, pkt_done, err_cmd, err_ovr, err_tmo} !== 30'd0)
            $display("FAIL reset_in: outputs=%h want 0",
                     {wr_en, wr_addr, wr_data, busy, pkt_done, err_cmd, err_ovr, err_tmo});
        else passed++;
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({wr_en, busy, pkt_done, err_cmd, err_ovr, err_tmo} !== 6'd0)
            $display("FAIL reset_out: flags=%b want 000000",
                     {wr_en, busy, pkt_done, err_cmd, err_ovr, err_tmo});
        else passed++;
        m_ptr = 0;
    endtask

    task automatic test_set_addr_raw();
        mark();
        pkt_addr(100, 0);
        wait_idle();
        checks++;
        if (done_cnt - d_base !== 1 || wq.size() - w_base !== 0)
            $display("FAIL set_addr: done=%0d writes=%0d want 1/0",
                     done_cnt - d_base, wq.size() - w_base);
        else passed++;
        mark();
        raw_src = '{8'h05, 8'h07};
        pkt_raw(2, 0);
        wait_idle();
        checks++;
        if (wr_mismatch() !== 0) $display("FAIL raw_writes: mismatches=%0d want 0", wr_mismatch());
        else passed++;
        checks++;
        if (raw_lat_bad() !== 0) $display("FAIL raw_latency: bad=%0d want 0", raw_lat_bad());
        else passed++;
        checks++;
        if (done_cnt - d_base !== 1 || done_cyc !== last_wr_cyc() + 1)
            $display("FAIL raw_done: count=%0d cyc=%0d want 1 at %0d",
                     done_cnt - d_base, done_cyc, last_wr_cyc() + 1);
        else passed++;
    endtask

    task automatic test_wrap_fill();
        int first_c;
        mark();
        pkt_addr(MaxA - 1, 1);
        pkt_fill(3, 8'h06, 0);
        first_c = byte_cyc + 1;
        wait_idle();
        checks++;
        if (wr_mismatch() !== 0) $display("FAIL wrap_writes: mismatches=%0d want 0", wr_mismatch());
        else passed++;
        checks++;
        if (busy_cnt - b_base !== 3) $display("FAIL fill_busy: cycles=%0d want 3", busy_cnt - b_base);
        else passed++;
        checks++;
        if (wq.size() - w_base !== 3 || wq[w_base].cyc !== first_c || last_wr_cyc() !== first_c + 2)
            $display("FAIL fill_timing: last=%0d want first %0d last %0d",
                     last_wr_cyc(), first_c, first_c + 2);
        else passed++;
        checks++;
        if (done_cyc !== first_c + 3 || bad_addr !== 0)
            $display("FAIL fill_done: done_cyc=%0d bad_addr=%0d want %0d/0",
                     done_cyc, bad_addr, first_c + 3);
        else passed++;
    endtask

    task automatic test_len0_bad_cmd();
        int a;
        mark();
        pkt_fill(0, 8'h03, 0);
        wait_idle();
        checks++;
        if (wq.size() - w_base !== 0 || done_cnt - d_base !== 1)
            $display("FAIL len0: writes=%0d done=%0d want 0/1", wq.size() - w_base,
                     done_cnt - d_base);
        else passed++;
        send(8'hA5, 0);
        send(8'h7E, 0);
        tick();
        checks++;
        if (err_cmd !== 1'b1) $display("FAIL bad_cmd: err_cmd=%b want 1", err_cmd);
        else passed++;
        mark();
        a = $urandom_range(0, MaxA - 1);
        pkt_addr(a, 0);
        pkt_raw(1, 0);
        wait_idle();
        checks++;
        if (wr_mismatch() !== 0 || done_cnt - d_base !== 2)
            $display("FAIL after_bad_cmd: mismatches=%0d done=%0d want 0/2", wr_mismatch(),
                     done_cnt - d_base);
        else passed++;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        checks++;
        if (err_cmd !== 1'b0) $display("FAIL cmd_clr: err_cmd=%b want 0", err_cmd);
        else passed++;
    endtask

    task automatic test_bad_addr();
        mark();
        pkt_addr(MaxA, 0);
        tick();
        checks++;
        if (err_cmd !== 1'b1 || done_cnt - d_base !== 0)
            $display("FAIL bad_addr: err_cmd=%b done=%0d want 1/0", err_cmd, done_cnt - d_base);
        else passed++;
        pkt_raw(1, 0);
        wait_idle();
        checks++;
        if (wr_mismatch() !== 0) $display("FAIL bad_addr_ptr: mismatches=%0d want 0", wr_mismatch());
        else passed++;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    endtask

    task automatic test_overrun();
        mark();
        pkt_fill(256, 8'(($urandom & 8'hF8) | 8'h02), 0);
        repeat (100) tick();
        // Clear and overrun in the same cycle: the set must win.
        rx_data = 8'($urandom); rx_valid = 1'b1; err_clr = 1'b1;
        tick();
        rx_valid = 1'b0; err_clr = 1'b0;
        wait_idle();
        checks++;
        if (err_ovr !== 1'b1) $display("FAIL ovr_set: err_ovr=%b want 1", err_ovr);
        else passed++;
        checks++;
        if (wr_mismatch() !== 0 || done_cnt - d_base !== 1)
            $display("FAIL ovr_fill: mismatches=%0d done=%0d want 0/1", wr_mismatch(),
                     done_cnt - d_base);
        else passed++;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        checks++;
        if (err_ovr !== 1'b0) $display("FAIL ovr_clr: err_ovr=%b want 0", err_ovr);
        else passed++;
    endtask

    task automatic test_random();
        int kind;
        logic [7:0] col;
        mark();
        for (int p = 0; p < 16; p++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 1) pkt_addr(MaxA - 1 - $urandom_range(0, 8), $urandom_range(0, 2));
                else pkt_addr($urandom_range(0, MaxA - 1), $urandom_range(0, 2));
            end else if (kind == 1) begin
                col = 8'($urandom);
                if (col == 8'hA5) col = 8'h05;
                pkt_fill($urandom_range(0, 20), col, $urandom_range(0, 2));
            end else begin
                pkt_raw($urandom_range(0, 12), $urandom_range(0, 2));
            end
            wait_idle();
        end
        checks++;
        if (wr_mismatch() !== 0) $display("FAIL rand_writes: mismatches=%0d want 0", wr_mismatch());
        else passed++;
        checks++;
        if (done_cnt - d_base !== exp_done)
            $display("FAIL rand_done: count=%0d want %0d", done_cnt - d_base, exp_done);
        else passed++;
        checks++;
        if ({err_cmd, err_ovr, err_tmo} !== 3'b000 || bad_addr !== 0)
            $display("FAIL rand_errs: errs=%b bad_addr=%0d want 000/0",
                     {err_cmd, err_ovr, err_tmo}, bad_addr);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        mark();
        send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0); send(8'h04, 0);
        b = 8'($urandom);
        send(b, 0);
        ew.push_back('{m_ptr, int'(b[2:0])});
        m_ptr = (m_ptr + 1) % MaxA;
        repeat (Tmo - 3) tick();
        checks++;
        if (err_tmo !== 1'b0) $display("FAIL tmo_early: err_tmo=%b want 0", err_tmo);
        else passed++;
        repeat (6) tick();
        checks++;
        if (err_tmo !== 1'b1) $display("FAIL tmo_set: err_tmo=%b want 1", err_tmo);
        else passed++;
        checks++;
        if (wr_mismatch() !== 0 || done_cnt - d_base !== 0)
            $display("FAIL tmo_partial: mismatches=%0d done=%0d want 0/0", wr_mismatch(),
                     done_cnt - d_base);
        else passed++;
        pkt_addr($urandom_range(0, MaxA - 1), 0);
        wait_idle();
        checks++;
        if (done_cnt - d_base !== 1) $display("FAIL tmo_idle: done=%0d want 1", done_cnt - d_base);
        else passed++;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    endtask

    task automatic test_reset_mid_fill();
        mark();
        pkt_fill(50, 8'h07, 0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_async: wr_en=%b busy=%b want 0/0", wr_en, busy);
        else passed++;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        tick();
        mark();
        pkt_raw(1, 0);
        wait_idle();
        checks++;
        if (wr_mismatch() !== 0) $display("FAIL rst_ptr: mismatches=%0d want 0", wr_mismatch());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_set_addr_raw();
        test_wrap_fill();
        test_len0_bad_cmd();
        test_bad_addr();
        test_overrun();
        test_random();
        test_timeout();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Packet parser between the UART byte receiver and the frame-buffer RAM write port.
- Consumes the received byte stream (data plus one-cycle done strobe) and decodes framed commands: set write pointer, run-length fill, raw pixel stream.
- Produces single-cycle 3-bit pixel writes with a 19-bit address into the 640x480 display RAM.
- Replaces the free-running write counter with an addressable, wrap-correct, error-checked loader.

Parameters:
WIDTH, 640, display width in pixels
HEIGHT, 480, display height in pixels
MAX_ADDR, WIDTH*HEIGHT, number of pixel words; valid addresses are 0..MAX_ADDR-1
SYNC_BYTE, 8'hA5, packet start marker
TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes inside a packet

Ports:
clk  in  1  system clock (clk_sys domain)
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
err_clr  in  1  clears sticky error flags
wr_en  out  1  RAM write strobe, one pixel per cycle
wr_addr  out  19  RAM write address
wr_data  out  3  pixel colour index
busy  out  1  high while in FILL state
pkt_done  out  1  one-cycle pulse when a packet completes
err_cmd  out  1  sticky: unknown command byte or address >= MAX_ADDR
err_ovr  out  1  sticky: rx_valid seen while busy
err_tmo  out  1  sticky: inter-byte timeout inside a packet

Behaviour:
- Reset (async, rst=1): state IDLE; wr_ptr=0; all outputs 0.
- Packet format (multi-byte fields big-endian): SYNC, CMD, payload.
  - CMD 8'h01 SET_ADDR: 3 bytes; address = bits [18:0] of the 24-bit value.
  - CMD 8'h02 FILL: LEN_H, LEN_L, COLOR.
  - CMD 8'h03 RAW: LEN_H, LEN_L, then LEN bytes; pixel = byte[2:0].
- States: IDLE, CMD, ADDR (byte cnt 0..2), LEN (cnt 0..1), COLOR, FILL, RAW.
- IDLE: non-SYNC bytes are ignored silently. SYNC -> CMD.
- CMD: 01 -> ADDR, 02/03 -> LEN. Any other value: set err_cmd, go to IDLE.
- ADDR: after the 3rd byte, if value < MAX_ADDR, load wr_ptr and pulse pkt_done; otherwise set err_cmd and leave wr_ptr unchanged. Next state IDLE.
- LEN = 0: pkt_done next cycle, no writes, state IDLE (applies to both FILL and RAW).
- FILL: entered the cycle after COLOR is accepted.
  - wr_en=1 for exactly LEN consecutive cycles; wr_data=COLOR; wr_addr=wr_ptr; wr_ptr increments each write.
  - busy=1 for the whole FILL state.
  - pkt_done pulses in the cycle after the last write.
- RAW: each accepted byte produces wr_en=1 exactly one cycle later at wr_ptr, then wr_ptr increments. After LEN bytes, pkt_done pulses with the last write's following cycle.
- Wrap: wr_ptr == MAX_ADDR-1 followed by a write -> wr_ptr = 0. Address MAX_ADDR is never driven.
- Overrun: rx_valid during FILL sets err_ovr; the byte is dropped and FILL continues.
- Timeout: counter resets on every rx_valid; runs only in CMD, ADDR, LEN, COLOR, RAW.
  - Reaching TIMEOUT_CYC sets err_tmo and returns to IDLE.
  - No partial packet effects are reverted; RAW writes already issued stand.
- err_clr has priority below a same-cycle set: the flag stays 1.
- Outputs are registered; wr_en/wr_addr/wr_data change only on clk edges.
- rst asserted mid-FILL or mid-RAW: immediate return to IDLE; wr_en drops asynchronously; wr_ptr=0.

Test Plan:
- Reset then A5 01 00 00 64 -> pkt_done pulse, no wr_en; then A5 03 00 02 05 07 -> writes (100,5) and (101,7), pkt_done once.
- A5 01 04 AF FF (addr 307199), then A5 02 00 03 06 -> writes at 307199, 0, 1 with data 6; busy high exactly 3 cycles.
- A5 02 00 00 03 -> no writes, pkt_done pulse; A5 7E -> err_cmd=1, return to IDLE; next A5 01 ... still decodes correctly.
- A5 01 04 B0 00 (307200) -> err_cmd=1, wr_ptr unchanged (checked by a following 1-pixel RAW write).
- A5 02 01 00 02 (256-cycle fill), inject rx_valid mid-fill -> err_ovr=1, 256 writes still issued; err_clr -> err_ovr=0.
- A5 03 00 04 01, then silence for TIMEOUT_CYC cycles -> one write done, err_tmo=1, IDLE; separately, rst pulse mid-FILL -> wr_en=0 immediately and wr_ptr=0.
